// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg
//   Shared constants and types for the I2S transmit path.
//   slot_width : bits per channel slot (samples are MSB-justified in it)
//   frame_bits : bits per stereo frame (left slot followed by right slot)
//   bit_idx_t  : position of the current bit within a frame
//   frame_pack : joins two justified slots into one frame word, left first

package i2s_tx_pkg;

    localparam int slot_width = 32;
    localparam int frame_bits = 64;
    localparam int bit_idx_w  = 6;

    typedef logic [bit_idx_w-1:0]  bit_idx_t;
    typedef logic [slot_width-1:0] slot_t;
    typedef logic [frame_bits-1:0] frame_t;

    // Last bit position of a frame; the next fall event starts a new frame.
    localparam bit_idx_t last_bit_idx = bit_idx_t'(frame_bits - 1);

    function automatic frame_t frame_pack(input slot_t left_slot, input slot_t right_slot);
        return {left_slot, right_slot};
    endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// i2s_sclk_gen
//   Divides clk_i down to the I2S bit clock.
//   clk_i    : main clock
//   reset_i  : asynchronous, active-high reset
//   sclk_o   : registered bit clock, high for the second half of each period
//   fall_o   : high in the clk_i cycle that ends with the divider wrapping to 0;
//              the edge closing that cycle is the sclk falling edge, and the
//              serializer updates all of its serial state on that edge

module i2s_sclk_gen #(
    parameter int sclk_half_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic sclk_o,
    output logic fall_o
);

    localparam int cnt_w = (2 * sclk_half_p > 2) ? $clog2(2 * sclk_half_p) : 1;
    localparam logic [cnt_w-1:0] div_last = cnt_w'(2 * sclk_half_p - 1);
    localparam logic [cnt_w-1:0] div_half = cnt_w'(sclk_half_p);

    logic [cnt_w-1:0] div_cnt;
    logic [cnt_w-1:0] div_nxt;

    always_comb begin
        div_nxt = div_cnt + 1'b1;
        if (div_cnt == div_last) begin
            div_nxt = '0;
        end
    end

    // sclk is derived from the next count so the flop output tracks
    // div_cnt >= sclk_half_p exactly, with no combinational path to the pin.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            sclk_o  <= (div_nxt >= div_half);
        end
    end

    assign fall_o = (div_cnt == div_last);

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Accepts stereo sample pairs on a valid/ready interface and drives an I2S
//   DAC directly. One sample pair is buffered; each 64-bit frame loads the
//   buffer into the shift register, or silence if the buffer is empty.
//   clk_i        : main clock
//   reset_i      : asynchronous, active-high reset
//   data_left_i  : left-channel sample (width_p bits)
//   data_right_i : right-channel sample (width_p bits)
//   valid_i      : sample pair valid
//   ready_o      : buffer can accept a sample pair
//   sclk_o       : I2S bit clock, clk_i / (2*sclk_half_p)
//   lrck_o       : word select, 0 = left, 1 = right
//   sdout_o      : I2S serial data, MSB first, one sclk after lrck changes
//   underrun_o   : one-cycle pulse when a frame loads with no buffered sample

module i2s_tx_serializer
    import i2s_tx_pkg::*;
#(
    parameter int width_p     = 24,
    parameter int sclk_half_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_left_i,
    input  logic [width_p-1:0] data_right_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               sclk_o,
    output logic               lrck_o,
    output logic               sdout_o,
    output logic               underrun_o
);

    logic               fall;
    logic               load;
    logic               accept;
    bit_idx_t           bit_idx;
    bit_idx_t           bit_idx_nxt;
    logic               buf_full;
    logic [width_p-1:0] buf_left;
    logic [width_p-1:0] buf_right;
    frame_t             sr;

    // Places a sample at the top of its slot; the low bits become zero padding.
    function automatic slot_t justify(input logic [width_p-1:0] sample);
        slot_t wide;
        wide = slot_t'(sample);
        return wide << (slot_width - width_p);
    endfunction

    i2s_sclk_gen #(
        .sclk_half_p (sclk_half_p)
    ) u_sclk_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sclk_o  (sclk_o),
        .fall_o  (fall)
    );

    assign bit_idx_nxt = bit_idx + 1'b1;
    assign load        = fall && (bit_idx == last_bit_idx);
    assign ready_o     = ~buf_full;
    assign accept      = valid_i && !buf_full;

    // ---- sample buffer ----
    // A load drains a full buffer; an accept can only happen when it is empty,
    // so the two never collide. An accept coinciding with a load of an empty
    // buffer fills the buffer for the following frame (no bypass).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_full <= 1'b0;
        end else if (load && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            buf_left  <= data_left_i;
            buf_right <= data_right_i;
        end
    end

    // ---- frame shifter ----
    // sdout_o always takes the pre-shift MSB, which delays data by one sclk
    // against lrck_o: the last right-slot bit goes out while lrck_o is already
    // low, and the left MSB follows at bit_idx 1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bit_idx    <= last_bit_idx;
            lrck_o     <= 1'b1;
            sdout_o    <= 1'b0;
            sr         <= '0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            if (fall) begin
                bit_idx <= bit_idx_nxt;
                lrck_o  <= bit_idx_nxt[bit_idx_w-1];
                sdout_o <= sr[frame_bits-1];
                if (load) begin
                    if (buf_full) begin
                        sr <= frame_pack(justify(buf_left), justify(buf_right));
                    end else begin
                        sr         <= '0;
                        underrun_o <= 1'b1;
                    end
                end else begin
                    sr <= {sr[frame_bits-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
//   Directed/randomized bench for i2s_tx_serializer. A reference model tracks
//   the serial stream as a list of frame words indexed by frame number and
//   derives every expected pin value from clock-edge counts.

module tb_i2s_tx_serializer;

    localparam int H         = 2;
    localparam int W         = 24;
    localparam int FRAME_CYC = 128 * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_i;
    logic [W-1:0] dl, dr;
    logic         valid;
    logic         ready, sclk, lrck, sd, und;

    logic [31:0]  dl32, dr32;
    logic         valid32;
    logic         ready32, sclk32, lrck32, sd32, und32;

    i2s_tx_serializer #(.width_p(W), .sclk_half_p(H)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .data_left_i  (dl),
        .data_right_i (dr),
        .valid_i      (valid),
        .ready_o      (ready),
        .sclk_o       (sclk),
        .lrck_o       (lrck),
        .sdout_o      (sd),
        .underrun_o   (und)
    );

    i2s_tx_serializer #(.width_p(32), .sclk_half_p(H)) dut32 (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .data_left_i  (dl32),
        .data_right_i (dr32),
        .valid_i      (valid32),
        .ready_o      (ready32),
        .sclk_o       (sclk32),
        .lrck_o       (lrck32),
        .sdout_o      (sd32),
        .underrun_o   (und32)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // reference model state
    int           k;
    int           f;
    int           nf;
    bit           m_full;
    logic [W-1:0] m_l, m_r;
    logic [63:0]  frm [0:255];
    logic         e_sclk, e_lrck, e_sd, e_und;
    bit           chk32_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [W-1:0] l, input logic [W-1:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    task automatic model_reset();
        k      = 0;
        f      = 0;
        nf     = 0;
        m_full = 1'b0;
        e_sclk = 1'b0;
        e_lrck = 1'b1;
        e_sd   = 1'b0;
        e_und  = 1'b0;
    endtask

    // One clk_i rising edge: sclk falls every 2*H edges; the frame starts on
    // fall 1, 65, 129, ... and data trails lrck by one bit.
    task automatic model_edge();
        bit acc;
        k++;
        e_und = 1'b0;
        acc   = valid && !m_full;
        if (k % (2 * H) == 0) begin
            f++;
            e_lrck = (((f - 1) % 64) >= 32);
            if (f >= 2) e_sd = frm[(f - 2) / 64][63 - ((f - 2) % 64)];
            else        e_sd = 1'b0;
            if ((f - 1) % 64 == 0) begin
                if (m_full) begin
                    frm[nf] = frame_of(m_l, m_r);
                    m_full  = 1'b0;
                end else begin
                    frm[nf] = '0;
                    e_und   = 1'b1;
                end
                if (nf < 255) nf++;
            end
        end
        if (acc) begin
            m_full = 1'b1;
            m_l    = dl;
            m_r    = dr;
        end
        e_sclk = ((k % (2 * H)) >= H);
    endtask

    task automatic check_outputs();
        chk("sclk",     64'(sclk),  64'(e_sclk));
        chk("lrck",     64'(lrck),  64'(e_lrck));
        chk("sdout",    64'(sd),    64'(e_sd));
        chk("ready",    64'(ready), 64'(!m_full));
        chk("underrun", 64'(und),   64'(e_und));
        if (chk32_en && (k % (2 * H) == 0)) begin
            if (f == 1) chk("w32_no_underrun", 64'(und32), 64'd0);
            if (f == 2) begin
                chk("w32_left_msb", 64'(sd32),   64'd1);
                chk("w32_lrck_l",   64'(lrck32), 64'd0);
            end
            if (f == 34) begin
                chk("w32_right_msb", 64'(sd32),   64'd0);
                chk("w32_lrck_r",    64'(lrck32), 64'd1);
            end
            if (f == 64) begin
                chk("w32_right_b1", 64'(sd32),   64'd0);
                chk("w32_lrck_b63", 64'(lrck32), 64'd1);
            end
            if (f == 65) begin
                chk("w32_right_lsb", 64'(sd32),   64'd1);
                chk("w32_lrck_b0",   64'(lrck32), 64'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_i) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit found;

        reset_i  = 1'b1;
        valid    = 1'b0;
        valid32  = 1'b0;
        dl       = '0;
        dr       = '0;
        dl32     = '0;
        dr32     = '0;
        chk32_en = 1'b1;
        model_reset();
        #1;
        chk("rst_sclk",     64'(sclk),  64'd0);
        chk("rst_lrck",     64'(lrck),  64'd1);
        chk("rst_sdout",    64'(sd),    64'd0);
        chk("rst_ready",    64'(ready), 64'd1);
        chk("rst_underrun", 64'(und),   64'd0);
        repeat (3) step();
        reset_i = 1'b0;

        // 32-bit instance gets one pair before its first load; the 24-bit
        // instance idles so its first frame is an underrun.
        valid32 = 1'b1;
        dl32    = 32'hFFFF_FFFF;
        dr32    = 32'h0000_0001;
        step();
        valid32 = 1'b0;
        repeat (300) step();
        chk32_en = 1'b0;

        // fixed pattern ahead of a load
        valid = 1'b1;
        dl    = 24'hA5_0F3C;
        dr    = 24'h80_0001;
        step();
        valid = 1'b0;
        repeat (600) step();

        // continuous valid with changing samples
        valid = 1'b1;
        repeat (1024) begin
            dl = W'($urandom);
            dr = W'($urandom);
            step();
        end
        valid = 1'b0;

        // valid exactly in the load cycle with an empty buffer
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (!m_full && ((k + 1) % FRAME_CYC) == 2 * H) found = 1'b1;
            else step();
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $error("FAIL wait_load_cycle: observed timeout expected load cycle");
        end
        valid = 1'b1;
        dl    = W'($urandom);
        dr    = W'($urandom);
        step();
        valid = 1'b0;
        chk("nobypass_underrun", 64'(und),   64'd1);
        chk("nobypass_ready",    64'(ready), 64'd0);
        repeat (600) step();

        // sparse random traffic
        repeat (1500) begin
            valid = ($urandom_range(0, 7) == 0);
            dl    = W'($urandom);
            dr    = W'($urandom);
            step();
        end
        valid = 1'b0;

        // reset in the middle of the right slot with the buffer full
        found = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 800 && !found; i++) begin
            if (m_full && f > 0 && ((f - 1) % 64) == 40 && (k % (2 * H)) == 1) found = 1'b1;
            else begin
                dl = W'($urandom);
                dr = W'($urandom);
                step();
            end
        end
        valid = 1'b0;
        if (!found) begin
            n_checks++;
            n_fail++;
            $error("FAIL wait_bit40: observed timeout expected bit_idx 40 with full buffer");
        end
        #3;
        reset_i = 1'b1;
        model_reset();
        #1;
        chk("midrst_sclk",     64'(sclk),  64'd0);
        chk("midrst_lrck",     64'(lrck),  64'd1);
        chk("midrst_sdout",    64'(sd),    64'd0);
        chk("midrst_ready",    64'(ready), 64'd1);
        chk("midrst_underrun", 64'(und),   64'd0);
        repeat (3) step();
        reset_i = 1'b0;
        repeat (600) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Transmit end of the line-out audio path: accepts stereo samples on a valid/ready interface and drives I2S serial clock, word-select (LR clock) and serial data to the DAC.
- Counterpart of the line-in deserialization path; lets the FPGA drive the codec directly without the AXIS bridge.
- Holds one sample in a buffer. On underrun it outputs silence.

Parameters:
width_p, 24, sample bits per channel (1..32), MSB-justified in a 32-bit slot
sclk_half_p, 4, clk_i cycles per sclk half-period (>=2)

Ports:
clk_i  in  1  main clock
reset_i  in  1  asynchronous, active-high reset
data_left_i  in  width_p  left-channel sample
data_right_i  in  width_p  right-channel sample
valid_i  in  1  sample pair valid
ready_o  out  1  buffer can accept a sample pair
sclk_o  out  1  I2S bit clock, clk_i/(2*sclk_half_p)
lrck_o  out  1  word select: 0 = left, 1 = right
sdout_o  out  1  I2S serial data
underrun_o  out  1  one-cycle pulse when a frame loads with no buffered sample

Behaviour:
- Reset state (async):
  - div_cnt=0, bit_idx=63, lrck_o=1, sclk_o=0, sdout_o=0.
  - Shift register 0, buffer empty, ready_o=1, underrun_o=0.
  - Reset mid-frame drops any buffered or shifting sample.
- Divider:
  - div_cnt counts 0..2*sclk_half_p-1 and wraps.
  - sclk_o=1 iff div_cnt>=sclk_half_p. sclk_o is registered and glitch-free.
- Fall event: the cycle where div_cnt wraps to 0 (sclk falls). All serial state changes only on fall events.
- On each fall event:
  - bit_idx <= bit_idx+1 mod 64.
  - lrck_o <= new bit_idx[5].
  - sdout_o <= sr[63].
  - sr <= sr<<1, except on a load.
- Load (fall event where new bit_idx=0):
  - lrck_o goes low.
  - sdout_o takes old sr[63], the last right-slot bit.
  - sr <= {L, zero pad to 32, R, zero pad to 32}. L/R come from the buffer if full (buffer then empties); otherwise sr <= 0 and underrun_o pulses for 1 cycle.
- I2S alignment:
  - Left MSB appears on sdout_o at bit_idx=1, one sclk after lrck falls.
  - Right MSB appears at bit_idx=33.
  - Padding bits are 0.
- Handshake:
  - ready_o = ~buf_full.
  - Accept when valid_i & ready_o; buffer captures both channels on that edge.
  - No bypass: a sample accepted in the same cycle as a load with empty buffer is not loaded. It waits in the buffer for the next frame, and underrun_o pulses.
  - Load and accept in the same cycle with buffer full: the load empties the buffer. ready_o was 0, so no accept occurs.
  - valid_i/data_i are ignored while ready_o=0.
- Latency:
  - First fall event is 2*sclk_half_p cycles after reset release.
  - Sample accepted before a load reaches sdout_o MSB 2*sclk_half_p cycles after that load.
  - Frame period is 128*sclk_half_p cycles.
- Throughput: at most one sample pair per frame. ready_o reasserts the cycle after the load.

Decomposition:
- Package i2s_tx_pkg: slot_width=32, frame_bits=64, bit index type (6 bits).
- Sub-module i2s_sclk_gen: divider producing sclk_o and the fall-event strobe.
- Buffer, shift register and bit counter live in the top module.

Test Plan:
- Reset, sclk_half_p=2, no valid -> sclk_o period 4 cycles, first fall at cycle 4; lrck_o 1->0; underrun_o pulses; sdout_o stays 0.
- Accept L=24'hA5_0F_3C, R=24'h80_0001 before first load -> sdout_o bits 1..24 = 101001010000111100111100, bits 25..32 = 0; bit 33 = 1, bits 34..55 = 0, bit 56 = 1; lrck_o=1 during bits 32..63.
- Hold valid_i=1 with incrementing samples -> exactly one accept per 256 cycles (half_p=2); ready_o low between accepts; no underrun_o after the first frame.
- Apply valid_i in the exact load cycle with empty buffer -> underrun_o=1, frame is silence, sample is transmitted next frame.
- Assert reset_i at bit_idx=40 with buffer full -> outputs return to reset values immediately; ready_o=1; no stale bits after release.
- width_p=32, L=32'hFFFF_FFFF, R=32'h0000_0001 -> right LSB 1 appears on sdout_o at the next frame's bit_idx=0 while lrck_o=0.
